// File: rtl/wasm_image_loader.sv
// rtl/wasm_image_loader.sv - boot-image loader: decodes typed byte-serial records into CPU load ports
// Record: TYPE, A[31:0] LE, L[31:0] LE, then L payload bytes for code/data records.
module wasm_image_loader #(
  parameter int unsigned CODE_SIZE = 65536,
  parameter int unsigned MEM_PAGES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_go,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        code_wr_en,
  output logic [31:0] code_wr_addr,
  output logic [7:0]  code_wr_data,
  output logic        mem_data_wr_en,
  output logic [31:0] mem_data_wr_addr,
  output logic [7:0]  mem_data_wr_data,
  output logic        mem_init_en,
  output logic [31:0] mem_init_pages,
  output logic [31:0] mem_init_max_pages,
  output logic        start,
  output logic [31:0] entry_func,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);

  typedef enum logic [3:0] {
    S_IDLE, S_TYPE, S_HDR, S_CHECK, S_PAYLOAD, S_MINIT, S_START, S_DONE, S_ERROR
  } state_t;

  localparam logic [32:0] CODE_LIMIT = 33'(CODE_SIZE);
  localparam logic [32:0] DATA_LIMIT = 33'(MEM_PAGES) << 16;

  state_t      state, state_next;
  logic [7:0]  rtype;
  logic [31:0] a, l, offset;
  logic [2:0]  hcnt;
  logic [32:0] rec_end;
  logic        accept, type_ok, code_oor, data_oor, last_byte;

  assign s_ready   = (state == S_TYPE) || (state == S_HDR) || (state == S_PAYLOAD);
  assign accept    = s_valid && s_ready;
  assign busy      = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERROR);
  assign type_ok   = (s_data != 8'h00) && (s_data <= 8'h04);
  // 33-bit sum so a huge A+L cannot wrap past the limit check
  assign rec_end   = {1'b0, a} + {1'b0, l};
  assign code_oor  = rec_end > CODE_LIMIT;
  assign data_oor  = rec_end > DATA_LIMIT;
  assign last_byte = (offset == l - 32'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (load_go) state_next = S_TYPE;
      S_TYPE:    if (accept) state_next = type_ok ? S_HDR : S_ERROR;
      S_HDR:     if (accept && hcnt == 3'd7) state_next = S_CHECK;
      S_CHECK: begin
        case (rtype)
          8'h01:   state_next = code_oor ? S_ERROR : (l == 32'd0) ? S_TYPE : S_PAYLOAD;
          8'h02:   state_next = data_oor ? S_ERROR : (l == 32'd0) ? S_TYPE : S_PAYLOAD;
          8'h03:   state_next = S_MINIT;
          8'h04:   state_next = S_START;
          default: state_next = S_ERROR;
        endcase
      end
      S_PAYLOAD: if (accept && last_byte) state_next = S_TYPE;
      S_MINIT:   state_next = S_TYPE;
      S_START:   state_next = S_DONE;
      S_DONE,
      S_ERROR:   if (load_go) state_next = S_TYPE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rtype              <= 8'h00;
      a                  <= 32'h0;
      l                  <= 32'h0;
      offset             <= 32'h0;
      hcnt               <= 3'd0;
      code_wr_en         <= 1'b0;
      code_wr_addr       <= 32'h0;
      code_wr_data       <= 8'h00;
      mem_data_wr_en     <= 1'b0;
      mem_data_wr_addr   <= 32'h0;
      mem_data_wr_data   <= 8'h00;
      mem_init_en        <= 1'b0;
      mem_init_pages     <= 32'h0;
      mem_init_max_pages <= 32'h0;
      start              <= 1'b0;
      entry_func         <= 32'h0;
      err_code           <= 2'd0;
    end else begin
      code_wr_en     <= 1'b0;
      mem_data_wr_en <= 1'b0;
      mem_init_en    <= 1'b0;
      start          <= 1'b0;
      case (state)
        S_TYPE: if (accept) begin
          rtype <= s_data;
          hcnt  <= 3'd0;
          if (!type_ok) err_code <= 2'd1;
        end
        // Little-endian fields fill from the top so byte 0 ends up in bits [7:0]
        S_HDR: if (accept) begin
          if (!hcnt[2]) a <= {s_data, a[31:8]};
          else          l <= {s_data, l[31:8]};
          hcnt <= hcnt + 3'd1;
        end
        S_CHECK: begin
          offset <= 32'h0;
          if (rtype == 8'h01 && code_oor) err_code <= 2'd2;
          if (rtype == 8'h02 && data_oor) err_code <= 2'd3;
        end
        S_PAYLOAD: if (accept) begin
          if (rtype == 8'h01) begin
            code_wr_en   <= 1'b1;
            code_wr_addr <= a + offset;
            code_wr_data <= s_data;
          end else begin
            mem_data_wr_en   <= 1'b1;
            mem_data_wr_addr <= a + offset;
            mem_data_wr_data <= s_data;
          end
          offset <= offset + 32'd1;
        end
        S_MINIT: begin
          mem_init_en        <= 1'b1;
          mem_init_pages     <= a;
          mem_init_max_pages <= l;
        end
        S_START: begin
          start      <= 1'b1;
          entry_func <= a;
        end
        S_DONE,
        S_ERROR: if (load_go) err_code <= 2'd0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wasm_image_loader.sv
// tb/tb_wasm_image_loader.sv - scoreboard bench for wasm_image_loader
// A record-level parser of each image predicts strobes; a monitor pops and compares them.
module tb_wasm_image_loader;
  localparam int unsigned CODE_SIZE = 65536;
  localparam int unsigned MEM_PAGES = 1;

  logic        clk = 1'b0, rst = 1'b1, load_go = 1'b0, s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, code_wr_en, mem_data_wr_en, mem_init_en, start, busy, done, error;
  logic [31:0] code_wr_addr, mem_data_wr_addr, mem_init_pages, mem_init_max_pages, entry_func;
  logic [7:0]  code_wr_data, mem_data_wr_data;
  logic [1:0]  err_code;

  wasm_image_loader #(.CODE_SIZE(CODE_SIZE), .MEM_PAGES(MEM_PAGES)) dut (
    .clk(clk), .rst(rst), .load_go(load_go),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .code_wr_en(code_wr_en), .code_wr_addr(code_wr_addr), .code_wr_data(code_wr_data),
    .mem_data_wr_en(mem_data_wr_en), .mem_data_wr_addr(mem_data_wr_addr),
    .mem_data_wr_data(mem_data_wr_data),
    .mem_init_en(mem_init_en), .mem_init_pages(mem_init_pages),
    .mem_init_max_pages(mem_init_max_pages),
    .start(start), .entry_func(entry_func),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_data;
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [63:0] exp_init[$];
  logic [31:0] exp_start[$];
  logic [7:0]  img[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (code_wr_en || mem_data_wr_en) begin
      chk("wr_exclusive", 64'(code_wr_en & mem_data_wr_en), 64'd0);
      chk("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
      if (exp_wr.size() != 0) begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr_kind", {62'd0, mem_data_wr_en, code_wr_en}, {62'd0, e.is_data, !e.is_data});
        chk("wr_addr", 64'(e.is_data ? mem_data_wr_addr : code_wr_addr), 64'(e.addr));
        chk("wr_data", 64'(e.is_data ? mem_data_wr_data : code_wr_data), 64'(e.data));
      end
    end
    if (mem_init_en) begin
      chk("init_expected", 64'(exp_init.size() != 0), 64'd1);
      if (exp_init.size() != 0)
        chk("init_pages_max", {mem_init_pages, mem_init_max_pages}, exp_init.pop_front());
    end
    if (start) begin
      chk("start_expected", 64'(exp_start.size() != 0), 64'd1);
      if (exp_start.size() != 0) chk("entry_func", 64'(entry_func), 64'(exp_start.pop_front()));
      chk("start_ready_done", {62'd0, s_ready, done}, 64'd1);
    end
  end

  // Record-level reference: walks the image, queues every effect, predicts final status.
  task automatic model(input logic [7:0] im[$], output int consumed, output int quiet,
                       output bit exp_done, output logic [1:0] exp_err);
    int pos = 0;
    bit stop = 0;
    logic [7:0] t;
    logic [31:0] ra, rl;
    quiet = 0; exp_done = 0; exp_err = 2'd0;
    while (!stop && pos < im.size()) begin
      t = im[pos]; pos++;
      if (t == 8'h00 || t > 8'h04) begin
        exp_err = 2'd1; stop = 1;
      end else begin
        ra = {im[pos+3], im[pos+2], im[pos+1], im[pos]};
        rl = {im[pos+7], im[pos+6], im[pos+5], im[pos+4]};
        pos += 8;
        quiet++;
        if (t == 8'h01 || t == 8'h02) begin
          longint lim = (t == 8'h01) ? longint'(CODE_SIZE) : longint'(MEM_PAGES) * 65536;
          if (longint'({32'd0, ra}) + longint'({32'd0, rl}) > lim) begin
            exp_err = (t == 8'h01) ? 2'd2 : 2'd3; stop = 1;
          end else begin
            for (int i = 0; i < int'(rl); i++)
              exp_wr.push_back('{t == 8'h02, ra + 32'(i), im[pos+i]});
            pos += int'(rl);
          end
        end else if (t == 8'h03) begin
          exp_init.push_back({ra, rl}); quiet++;
        end else begin
          exp_start.push_back(ra); quiet++; exp_done = 1; stop = 1;
        end
      end
    end
    consumed = pos;
  endtask

  task automatic add_hdr(input logic [7:0] t, input logic [31:0] ra, input logic [31:0] rl);
    img.push_back(t);
    for (int i = 0; i < 4; i++) img.push_back(ra[8*i +: 8]);
    for (int i = 0; i < 4; i++) img.push_back(rl[8*i +: 8]);
  endtask

  task automatic add_rand_payload(input int n);
    for (int i = 0; i < n; i++) img.push_back(8'($urandom));
  endtask

  task automatic pulse_go();
    load_go = 1'b1;
    @(posedge clk); #1;
    load_go = 1'b0;
  endtask

  // mode 0: always valid, 1: valid every other cycle, 2: random valid plus stray load_go
  task automatic run_image(input string name, input int mode);
    int consumed, quiet, idx = 0, cyc = 0, cnt_quiet = 0, budget;
    bit ed, acc, v;
    logic [1:0] ee;
    model(img, consumed, quiet, ed, ee);
    budget = 8 * img.size() + 100;
    pulse_go();
    while (!(done || error) && cyc < budget) begin
      if (busy && !s_ready) cnt_quiet++;
      case (mode)
        0:       v = 1'b1;
        1:       v = cyc[0];
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      load_go = (mode == 2) && busy && ($urandom_range(0, 15) == 0);
      s_valid = (idx < img.size()) && v;
      s_data  = (idx < img.size()) ? img[idx] : 8'h00;
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    s_valid = 1'b0; load_go = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_done"}, 64'(done), 64'(ed));
    chk({name, "_error"}, 64'(error), 64'(ee != 2'd0));
    chk({name, "_err_code"}, 64'(err_code), 64'(ee));
    chk({name, "_consumed"}, 64'(idx), 64'(consumed));
    chk({name, "_noaccept_cycles"}, 64'(cnt_quiet), 64'(quiet));
    chk({name, "_drained"}, 64'(exp_wr.size() + exp_init.size() + exp_start.size()), 64'd0);
    chk({name, "_idle_flags"}, {62'd0, busy, s_ready}, 64'd0);
    exp_wr.delete(); exp_init.delete(); exp_start.delete();
    img.delete();
  endtask

  task automatic check_zero(input string name);
    chk({name, "_flags"}, {53'd0, code_wr_en, mem_data_wr_en, mem_init_en, start, busy, done,
                           error, err_code, s_ready}, 64'd0);
    chk({name, "_wr_addrs"}, {code_wr_addr, mem_data_wr_addr}, 64'd0);
    chk({name, "_wr_data"}, {48'd0, code_wr_data, mem_data_wr_data}, 64'd0);
    chk({name, "_init"}, {mem_init_pages, mem_init_max_pages}, 64'd0);
    chk({name, "_entry"}, 64'(entry_func), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int m = 0; m < 2; m++) begin
      add_hdr(8'h01, 32'h100, 32'd3);
      img.push_back(8'hAA); img.push_back(8'hBB); img.push_back(8'hCC);
      add_hdr(8'h04, 32'd2, 32'd0);
      run_image(m == 0 ? "code_load" : "code_load_bp", m);
      chk("entry_held", 64'(entry_func), 64'd2);
    end

    add_hdr(8'h03, 32'd1, 32'd4);
    add_hdr(8'h02, 32'hFFFE, 32'd2);
    img.push_back(8'h11); img.push_back(8'h22);
    add_hdr(8'h04, 32'd0, 32'd0);
    run_image("minit_data", 0);
    chk("init_held", {mem_init_pages, mem_init_max_pages}, {32'd1, 32'd4});

    add_hdr(8'h01, 32'hFFFF, 32'd2);
    add_rand_payload(2);
    run_image("code_range", 0);
    pulse_go();
    chk("clear_after_go", {60'd0, error, err_code, busy}, 64'd1);

    // 32-bit A+L would wrap to 0x10 here; only a 33-bit compare rejects it
    add_hdr(8'h02, 32'hFFFF_FFF0, 32'h20);
    add_rand_payload(4);
    run_image("data_range_wrap", 2);

    img.push_back(8'h7E);
    add_hdr(8'h04, 32'd5, 32'd0);
    run_image("bad_type", 0);

    add_hdr(8'h01, CODE_SIZE - 2, 32'd2);
    add_rand_payload(2);
    add_hdr(8'h02, 32'hFFFF, 32'd1);
    add_rand_payload(1);
    add_hdr(8'h02, 32'h10, 32'd0);
    add_hdr(8'h04, 32'h77, 32'hDEAD);
    run_image("boundaries", 1);

    begin
      int idx = 0, cyc = 0;
      add_hdr(8'h01, 32'h200, 32'd5);
      img.push_back(8'h51); img.push_back(8'h52); img.push_back(8'h53);
      img.push_back(8'h54); img.push_back(8'h55);
      exp_wr.push_back('{1'b0, 32'h200, 8'h51});
      exp_wr.push_back('{1'b0, 32'h201, 8'h52});
      pulse_go();
      while (idx < 11 && cyc < 100) begin
        bit acc;
        s_valid = 1'b1; s_data = img[idx];
        acc = s_ready;
        @(posedge clk); #1;
        if (acc) idx++;
        cyc++;
      end
      s_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      check_zero("mid_reset");
      rst = 1'b0;
      chk("mid_reset_drained", 64'(exp_wr.size()), 64'd0);
      exp_wr.delete(); img.delete();
      @(posedge clk); #1;
      add_hdr(8'h01, 32'h300, 32'd2);
      add_rand_payload(2);
      add_hdr(8'h04, 32'd9, 32'd0);
      run_image("after_reset", 0);
    end

    for (int r = 0; r < 25; r++) begin
      int n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        int c = $urandom_range(0, 9);
        int ln = $urandom_range(0, 5);
        if (c < 4) begin
          add_hdr(8'h01, $urandom_range(0, 1) ? CODE_SIZE - ln : $urandom_range(0, CODE_SIZE - ln), ln);
          add_rand_payload(ln);
        end else if (c < 7) begin
          add_hdr(8'h02, $urandom_range(0, MEM_PAGES * 65536 - ln), ln);
          add_rand_payload(ln);
        end else begin
          add_hdr(8'h03, $urandom, $urandom);
        end
      end
      case ($urandom_range(0, 9))
        0: begin
          img.push_back($urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(5, 255)));
          add_rand_payload(4);
        end
        1: begin
          int ln = $urandom_range(1, 5);
          add_hdr(8'h01, CODE_SIZE - ln + $urandom_range(1, 100), ln);
          add_rand_payload(ln);
        end
        default: add_hdr(8'h04, $urandom, $urandom);
      endcase
      run_image("random", 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
